// File: rtl/ysyx_22050518_axi_sram_slave.sv
// AXI4 slave in front of a 2^DEPTH_LOG2 x 32-bit SRAM.
//   clk, rst          : single clock, synchronous active-high reset
//   axi_ar_* / axi_r_*: read address / read data channels (one burst in flight)
//   axi_aw_* / axi_w_*: write address / write data channels (one burst in flight)
//   axi_b_*           : write response channel
// Read and write engines are independent FSMs sharing only the array. Read
// data is combinational from the array, so a same-cycle write to the word
// being read shows the old value and the new one from the next cycle on.
module ysyx_22050518_axi_sram_slave #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  axi_ar_id,
    input  logic [1:0]  axi_ar_brust,
    input  logic [7:0]  axi_ar_len,
    input  logic [2:0]  axi_ar_size,
    input  logic [63:0] axi_ar_addr,
    input  logic        axi_ar_valid,
    output logic        axi_ar_ready,
    output logic [31:0] axi_r_data,
    output logic        axi_r_valid,
    output logic [3:0]  axi_r_id,
    output logic        axi_r_last,
    output logic [1:0]  axi_r_resp,
    input  logic        axi_r_ready,
    input  logic [3:0]  axi_aw_id,
    input  logic [1:0]  axi_aw_brust,
    input  logic [7:0]  axi_aw_len,
    input  logic [2:0]  axi_aw_size,
    input  logic [63:0] axi_aw_addr,
    input  logic        axi_aw_valid,
    output logic        axi_aw_ready,
    input  logic [31:0] axi_w_data,
    input  logic [3:0]  axi_w_strb,
    input  logic        axi_w_last,
    input  logic        axi_w_valid,
    output logic        axi_w_ready,
    output logic        axi_b_valid,
    output logic [1:0]  axi_b_resp,
    output logic [3:0]  axi_b_id,
    input  logic        axi_b_ready
);
    localparam int          WORDS = 1 << DEPTH_LOG2;
    // One past the last byte; 65 bits so a BASE near the top cannot wrap.
    localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'd4 << DEPTH_LOG2);

    typedef enum logic       {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [WORDS];

    function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [1:0] br);
        return (br == 2'b01) ? a + 64'd4 : a;
    endfunction

    // ---------------- read engine ----------------
    r_state_t        r_state;
    logic [3:0]      r_id_q;
    logic [63:0]     r_addr;
    logic [7:0]      r_len, r_cnt;
    logic [1:0]      r_brust;
    logic [2:0]      r_size;
    logic [63:0]     r_word_addr, r_off;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic            r_legal;

    assign r_word_addr = {r_addr[63:2], 2'b00};
    assign r_off       = r_word_addr - BASE_ADDR;
    assign r_idx       = r_off[DEPTH_LOG2+1:2];
    assign r_legal     = (r_word_addr >= BASE_ADDR) && ({1'b0, r_word_addr} < LIMIT) &&
                         (r_size == 3'b010) && !r_brust[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id_q  <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_brust <= '0;
            r_size  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (axi_ar_valid) begin
                    r_id_q  <= axi_ar_id;
                    r_addr  <= axi_ar_addr;
                    r_len   <= axi_ar_len;
                    r_brust <= axi_ar_brust;
                    r_size  <= axi_ar_size;
                    r_cnt   <= '0;
                    r_state <= R_BURST;
                end
                R_BURST: if (axi_r_ready) begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_addr <= next_addr(r_addr, r_brust);
                    if (r_cnt == r_len) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi_ar_ready = (r_state == R_IDLE);
    assign axi_r_valid  = (r_state == R_BURST);
    assign axi_r_id     = axi_r_valid ? r_id_q : 4'h0;
    assign axi_r_last   = axi_r_valid && (r_cnt == r_len);
    assign axi_r_data   = (axi_r_valid && r_legal) ? mem[r_idx] : 32'h0;
    assign axi_r_resp   = (axi_r_valid && !r_legal) ? 2'b10 : 2'b00;

    // ---------------- write engine ----------------
    w_state_t        w_state;
    logic [3:0]      w_id_q;
    logic [63:0]     w_addr;
    logic [7:0]      w_len, w_cnt;
    logic [1:0]      w_brust;
    logic [2:0]      w_size;
    logic            w_err;
    logic [63:0]     w_word_addr, w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic            w_legal, w_fire;

    assign w_word_addr = {w_addr[63:2], 2'b00};
    assign w_off       = w_word_addr - BASE_ADDR;
    assign w_idx       = w_off[DEPTH_LOG2+1:2];
    assign w_legal     = (w_word_addr >= BASE_ADDR) && ({1'b0, w_word_addr} < LIMIT) &&
                         (w_size == 3'b010) && !w_brust[1];
    assign w_fire      = (w_state == W_DATA) && axi_w_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id_q  <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_brust <= '0;
            w_size  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (axi_aw_valid) begin
                    w_id_q  <= axi_aw_id;
                    w_addr  <= axi_aw_addr;
                    w_len   <= axi_aw_len;
                    w_brust <= axi_aw_brust;
                    w_size  <= axi_aw_size;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (axi_w_valid) begin
                    w_cnt  <= w_cnt + 8'd1;
                    w_addr <= next_addr(w_addr, w_brust);
                    // Sticky: any illegal beat or a last that disagrees with len.
                    if (!w_legal || (axi_w_last && (w_cnt != w_len))) w_err <= 1'b1;
                    if (axi_w_last) w_state <= W_RESP;
                end
                W_RESP: if (axi_b_ready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array is never reset; a beat that lands during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_w_strb[i]) mem[w_idx][8*i +: 8] <= axi_w_data[8*i +: 8];
            end
        end
    end

    assign axi_aw_ready = (w_state == W_IDLE);
    assign axi_w_ready  = (w_state == W_DATA);
    assign axi_b_valid  = (w_state == W_RESP);
    assign axi_b_resp   = (axi_b_valid && w_err) ? 2'b10 : 2'b00;
    assign axi_b_id     = axi_b_valid ? w_id_q : 4'h0;

    // Byte-offset bits and out-of-window offset bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{r_addr[1:0], w_addr[1:0], r_off[1:0], w_off[1:0],
                           r_off[63:DEPTH_LOG2+2], w_off[63:DEPTH_LOG2+2]};
endmodule

// File: doc/ysyx_22050518_axi_sram_slave.md
YSYX_22050518_AXI_SRAM_SLAVE -- requirements
Module: ysyx_22050518_axi_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, giving 2^DEPTH_LOG2 32-bit words.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have AR inputs axi_ar_id 4, axi_ar_brust 2, axi_ar_len 8, axi_ar_size 3, axi_ar_addr 64, axi_ar_valid 1, and output axi_ar_ready 1.
REQ-006 SHALL have R outputs axi_r_data 32, axi_r_valid 1, axi_r_id 4, axi_r_last 1, axi_r_resp 2, and input axi_r_ready 1.
REQ-007 SHALL have AW inputs axi_aw_id 4, axi_aw_brust 2, axi_aw_len 8, axi_aw_size 3, axi_aw_addr 64, axi_aw_valid 1, and output axi_aw_ready 1.
REQ-008 SHALL have W inputs axi_w_data 32, axi_w_strb 4, axi_w_last 1, axi_w_valid 1, and output axi_w_ready 1.
REQ-009 SHALL have B outputs axi_b_valid 1, axi_b_resp 2, axi_b_id 4, and input axi_b_ready 1.

Function
REQ-010 SHALL hold the storage as a 2^DEPTH_LOG2 x 32 array with independent read and write paths; array contents are not reset.
REQ-011 Read FSM SHALL have states R_IDLE and R_BURST; axi_ar_ready = 1 only in R_IDLE.
REQ-012 AR handshake in R_IDLE: capture id, addr, len, brust, size; zero beat counter; go to R_BURST. The first axi_r_valid appears the next cycle, giving 1-cycle latency.
REQ-013 In R_BURST: axi_r_valid = 1; axi_r_id = captured id; axi_r_last = (counter == len); axi_r_data = word at current beat address, combinational from the array.
REQ-014 On axi_r_valid & axi_r_ready: counter +1 and address advanced; if axi_r_last, return to R_IDLE. Otherwise, all R outputs SHALL hold stable while axi_r_ready = 0.
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; axi_aw_ready = 1 only in W_IDLE; axi_w_ready = 1 only in W_DATA.
REQ-016 AW handshake: capture id, addr, len, brust, size; clear error flag; go to W_DATA.
REQ-017 Each W handshake SHALL write the byte lanes with axi_w_strb[i] = 1 at the current beat address, only if that beat is legal; then counter +1 and address advanced.
REQ-018 W handshake with axi_w_last = 1 SHALL go to W_RESP. If counter != len at that point, the error flag is set.
REQ-019 In W_RESP: axi_b_valid = 1, axi_b_id = captured id, axi_b_resp = 2'b10 if the error flag is set, else 2'b00. On axi_b_ready, go to W_IDLE.
REQ-020 Address advance rule: brust 2'b00 (FIXED) keeps the address; 2'b01 (INCR) adds 4 modulo 2^64.
REQ-021 Addresses SHALL be used word-aligned, with addr[1:0] ignored.
REQ-022 Word index SHALL be (addr - BASE_ADDR) >> 2.
REQ-023 A beat is illegal if any of the following holds: addr < BASE_ADDR; addr >= BASE_ADDR + 4*2^DEPTH_LOG2; size != 3'b010; brust is 2'b10 or 2'b11.
REQ-024 An illegal read beat SHALL return axi_r_data = 0 and axi_r_resp = 2'b10; a legal read beat SHALL return axi_r_resp = 2'b00.
REQ-025 An illegal write beat SHALL perform no array write and SHALL set the error flag.
REQ-026 Read and write FSMs SHALL run concurrently. A same-cycle read and write to the same word SHALL return the old data; the write is visible from the next cycle.
REQ-027 The block SHALL hold at most one outstanding read and one outstanding write burst; the next AR/AW is accepted only after returning to idle.

Reset
REQ-028 While rst = 1 at a clock edge: both FSMs SHALL go to idle and counters clear. Next-cycle outputs SHALL be: axi_ar_ready = 1, axi_aw_ready = 1, axi_w_ready = 0, axi_r_valid = 0, axi_b_valid = 0, axi_r_last = 0, and id/resp/data outputs = 0.
REQ-029 Reset mid-burst SHALL abandon the burst with no B or remaining R beats; array words already written SHALL keep their values.

Verification
REQ-030 AW addr 0x8000_0000, len 3, INCR, size 2, then data 11/22/33/44 strb 4'hF with w_last on beat 4 -> b_resp 00, b_id echoed. Then AR on the same address, len 3 -> r_data 11,22,33,44, r_last on the 4th beat only, first r_valid 1 cycle after AR.
REQ-031 Read len 1 while holding r_ready = 0 for 3 cycles -> r_data, r_id and r_last held stable; exactly 2 beats delivered.
REQ-032 Write 0xAABBCCDD with strb 4'b0101 over 0x0 -> readback 0x00BB00DD.
REQ-033 AR addr 0x7FFF_FFFC, len 0 -> r_resp 10, r_data 0. AW at BASE+4*4096 -> b_resp 10, no array change.
REQ-034 w_last asserted on beat 2 of a len-3 burst -> b_resp 10. FIXED burst len 2 -> all beats hit the same word.
REQ-035 rst asserted during beat 2 of a len-7 read and a pending write -> next cycle r_valid = 0, b_valid = 0, ar_ready = 1, aw_ready = 1, and a new AR is accepted normally.
